ps2_kbd_port: RTL and testbench
===============================

Name: ps2_kbd_port

Overview:
Keyboard input port for the eLC-3. It receives PS/2 frames on PS2_KBCLK/PS2_KBDAT, checks their framing, and buffers the scan codes in a small FIFO. It presents the LC-3 memory-mapped keyboard registers KBSR and KBDR to the memory/IO select logic, which feeds them onto the datapath Bus. It is the upstream stage that produces all keyboard data the CPU consumes.

Parameters:
FIFO_DEPTH, 8, number of buffered scan codes; must be a power of 2, minimum 2.
TIMEOUT_CYCLES, 50000, Clk cycles without a PS/2 falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
Clk  input  1  system clock (CLOCK_50 domain)
Reset_n  input  1  asynchronous active-low reset
PS2_KBCLK  input  1  raw PS/2 clock from keyboard, asynchronous
PS2_KBDAT  input  1  raw PS/2 data from keyboard, asynchronous
KBDR_Rd  input  1  one-cycle strobe: CPU read of KBDR completes; pops FIFO head
KBSR  output  16  {Ready, 15'b0}; Ready = FIFO non-empty
KBDR  output  16  {8'h00, FIFO head byte}; 16'h0000 when empty
Overrun  output  1  sticky: a valid byte was dropped because the FIFO was full
Frame_Err  output  1  one-cycle pulse on a discarded frame

Behaviour:
- Reset (async, Reset_n=0): FSM goes to IDLE; FIFO is emptied; shift register, bit count and timeout counter are cleared; sync flops are set to 1. Outputs: KBSR=16'h0000, KBDR=16'h0000, Overrun=0, Frame_Err=0. A partial frame is discarded silently (no Frame_Err).
- Input sync: PS2_KBCLK and PS2_KBDAT each pass through 2 flops. fe = prev_sync_clk & ~sync_clk, registered. All frame sampling uses sync data in the cycle fe=1.
- Frame format: start(0), D0..D7 LSB first, odd parity, stop(1). The parity bit makes the count of ones across D0..D7 plus parity odd.
- FSM states:
  - IDLE: on fe, if data=0 go to DATA with count=0; if data=1 ignore and stay in IDLE.
  - DATA: on fe, shift data into bit[count]; after the 8th bit go to PARITY.
  - PARITY: on fe, latch parity bit; go to STOP.
  - STOP: on fe, the frame is valid if stop=1 and parity is odd. Valid: push byte on this Clk edge. Invalid: discard and pulse Frame_Err next cycle. Return to IDLE either way.
- Timeout: in any state other than IDLE, the counter increments each cycle without fe and clears on fe. On reaching TIMEOUT_CYCLES: go to IDLE, discard, pulse Frame_Err.
- Latency: Ready=1 in the first cycle after the push edge, i.e. 4 Clk cycles after the raw falling edge of the stop bit (2 sync + 1 edge register + 1 push).
- FIFO: circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - KBDR reflects the head combinationally from the registered state.
  - KBDR_Rd while non-empty pops on the next edge. KBDR_Rd while empty is ignored; no pointer change.
  - Push while full (no simultaneous pop): byte is dropped and Overrun is set.
  - Push and pop in the same cycle, any fill level including full: both take effect, count is unchanged, and no overrun occurs.
- Overrun clears on the first KBDR_Rd after it is set. If a drop and a KBDR_Rd coincide, set wins.
- Frame_Err is exactly one cycle wide per discarded frame.

Test Plan:
- Scan code 0x1C: bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. Expect KBSR=16'h8000 and KBDR=16'h001C within 4 Clk of the stop edge. One KBDR_Rd pulse gives KBSR=16'h0000 and KBDR=16'h0000.
- Frame 0x1C with parity=1, then frame 0x1C with stop=0. Expect a one-cycle Frame_Err for each frame and KBSR held at 16'h0000 throughout.
- Nine valid frames 0x01..0x09 with no reads (FIFO_DEPTH=8). Expect Overrun=1 and KBSR=16'h8000. Eight reads return KBDR 0x0001..0x0008 in order, Overrun clears after the first read, and the FIFO is empty after the eighth read.
- Start bit plus 3 data bits, then PS2_KBCLK idle for longer than TIMEOUT (run with TIMEOUT_CYCLES=100). Expect one Frame_Err pulse and FSM in IDLE; a following frame 0x5A yields KBDR=16'h005A.
- FIFO full with 0x01..0x08, then KBDR_Rd asserted in the same cycle as the push of 0x09. Expect Overrun=0, count stays 8, and reads return 0x02..0x09.
- Reset_n pulled low during D4 of a frame. Expect all outputs 0 asynchronously and no Frame_Err. After release, a frame 0xF0 gives KBDR=16'h00F0.

Source files
------------

// File: rtl/ps2_kbd_port.sv
// ps2_kbd_port: PS/2 keyboard receiver with scan-code FIFO, exposing LC-3 KBSR/KBDR.
module ps2_kbd_port #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PS2_KBCLK,
    input  logic        PS2_KBDAT,
    input  logic        KBDR_Rd,
    output logic [15:0] KBSR,
    output logic [15:0] KBDR,
    output logic        Overrun,
    output logic        Frame_Err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [1:0] clk_s, dat_s;
    logic clk_prev, fe, sdat;
    logic [2:0] cnt;
    logic [7:0] sh;
    logic par, push, err, timeout;
    logic [TW-1:0] to_cnt;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic empty, full, pop, wr_en, drop;
    assign sdat = dat_s[1];
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            clk_prev <= 1'b1;
            fe       <= 1'b0;
        end else begin
            clk_s    <= {clk_s[0], PS2_KBCLK};
            dat_s    <= {dat_s[0], PS2_KBDAT};
            clk_prev <= clk_s[1];
            fe       <= clk_prev & ~clk_s[1];
        end
    end
    always_comb begin
        state_n = state;
        push    = 1'b0;
        err     = 1'b0;
        timeout = (state != IDLE) && !fe && (to_cnt == TO_LAST);
        if (timeout) begin
            state_n = IDLE;
            err     = 1'b1;
        end else if (fe) begin
            case (state)
                IDLE:    state_n = sdat ? IDLE : DATA;
                DATA:    state_n = (cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_n = STOP;
                default: begin
                    state_n = IDLE;
                    push    = sdat & (^{sh, par});
                    err     = ~(sdat & (^{sh, par}));
                end
            endcase
        end
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            Frame_Err <= 1'b0;
        end else begin
            state     <= state_n;
            Frame_Err <= err;
            to_cnt    <= (state == IDLE || fe || timeout) ? '0 : to_cnt + TW'(1);
            if (fe && state == IDLE) cnt <= '0;
            if (fe && state == DATA) begin
                sh[cnt] <= sdat;
                cnt     <= cnt + 3'd1;
            end
            if (fe && state == PARITY) par <= sdat;
        end
    end
    // A push while full is still accepted when a pop frees the head slot on the same edge.
    assign empty = (count == '0);
    assign full  = (count == FULL);
    assign pop   = KBDR_Rd & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            Overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count   <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            Overrun <= drop | (Overrun & ~KBDR_Rd);
        end
    end
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= sh;
    end
    assign KBSR = {~empty, 15'b0};
    assign KBDR = {8'h00, empty ? 8'h00 : mem[rd_ptr]};
endmodule

// File: tb/tb_ps2_kbd_port.sv
// tb_ps2_kbd_port: directed and randomized PS/2 frames checked against a queue-based keyboard model.
module tb_ps2_kbd_port;
    localparam int H = 8;
    logic clk = 1'b0, rst_n = 1'b1, kbclk = 1'b1, kbdat = 1'b1, rd = 1'b0;
    logic [15:0] kbsr, kbdr;
    logic ovr, ferr, ferr_d = 1'b0;
    int n_checks = 0, n_pass = 0, err_cycles = 0, err_pulses = 0, m_err = 0;
    byte unsigned q[$];
    logic m_ovr = 1'b0;

    ps2_kbd_port #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)) dut (
        .Clk(clk), .Reset_n(rst_n), .PS2_KBCLK(kbclk), .PS2_KBDAT(kbdat),
        .KBDR_Rd(rd), .KBSR(kbsr), .KBDR(kbdr), .Overrun(ovr), .Frame_Err(ferr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr) err_cycles++;
        if (ferr && !ferr_d) err_pulses++;
        ferr_d = ferr;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, " KBSR"}, kbsr, {q.size() != 0, 15'b0});
        check({tag, " KBDR"}, kbdr, q.size() != 0 ? {8'h00, q[0]} : 16'h0000);
        check({tag, " Overrun"}, {15'b0, ovr}, {15'b0, m_ovr});
    endtask

    task automatic check_err(input string tag);
        check({tag, " err cycles"}, 16'(err_cycles), 16'(m_err));
        check({tag, " err pulses"}, 16'(err_pulses), 16'(m_err));
    endtask

    task automatic model_frame(input byte unsigned d, input logic ok);
        if (!ok) m_err++;
        else if (q.size() < 8) q.push_back(d);
        else m_ovr = 1'b1;
    endtask

    task automatic model_read();
        if (q.size() != 0) void'(q.pop_front());
        m_ovr = 1'b0;
    endtask

    task automatic half();
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic bit_fall(input logic b);
        kbdat = b;
        half();
        kbclk = 1'b0;
    endtask

    task automatic bit_rise();
        half();
        kbclk = 1'b1;
    endtask

    // Drives a whole frame up to and including the falling edge of the stop bit.
    task automatic send_head(input byte unsigned d, input logic bad_par, input logic stop);
        logic p;
        p = (($countones(d) % 2) == 0) ^ bad_par;
        bit_fall(1'b0);
        bit_rise();
        for (int i = 0; i < 8; i++) begin
            bit_fall(d[i]);
            bit_rise();
        end
        bit_fall(p);
        bit_rise();
        bit_fall(stop);
    endtask

    task automatic finish_frame();
        bit_rise();
        kbdat = 1'b1;
        half();
    endtask

    task automatic send_frame(input byte unsigned d, input logic bad_par, input logic stop);
        send_head(d, bad_par, stop);
        finish_frame();
        model_frame(d, !bad_par && stop);
    endtask

    task automatic do_read();
        @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        model_read();
    endtask

    initial begin
        byte unsigned d;
        int f, nr;
        #2 rst_n = 1'b0;
        #2;
        check("reset KBSR", kbsr, 16'h0000);
        check("reset KBDR", kbdr, 16'h0000);
        check("reset Overrun", {15'b0, ovr}, 16'h0000);
        check("reset Frame_Err", {15'b0, ferr}, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        half();

        send_head(8'h1C, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("latency early KBSR", kbsr, 16'h0000);
        @(posedge clk);
        #1 check("latency KBSR", kbsr, 16'h8000);
        check("latency KBDR", kbdr, 16'h001C);
        model_frame(8'h1C, 1'b1);
        finish_frame();
        do_read();
        check_model("1C after read");

        send_frame(8'h1C, 1'b1, 1'b1);
        check_model("bad parity");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_model("bad stop");
        check_err("framing errors");

        for (int i = 1; i <= 9; i++) send_frame(byte'(i), 1'b0, 1'b1);
        check_model("overfill");
        for (int i = 0; i < 8; i++) begin
            do_read();
            check_model("drain");
        end

        bit_fall(1'b0);
        bit_rise();
        for (int i = 0; i < 3; i++) begin
            bit_fall(i[0]);
            bit_rise();
        end
        kbdat = 1'b1;
        repeat (150) @(posedge clk);
        #1 m_err++;
        check_err("timeout");
        send_frame(8'h5A, 1'b0, 1'b1);
        check_model("after timeout");
        do_read();

        for (int i = 1; i <= 8; i++) send_frame(byte'(i), 1'b0, 1'b1);
        check_model("full");
        send_head(8'h09, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        model_read();
        model_frame(8'h09, 1'b1);
        check_model("push+pop when full");
        finish_frame();
        for (int i = 0; i < 8; i++) begin
            do_read();
            check_model("drain 2..9");
        end

        for (int n = 0; n < 24; n++) begin
            d = byte'($urandom);
            f = int'($urandom_range(0, 5));
            send_frame(d, f == 0, f != 1);
            check_model("random frame");
            nr = int'($urandom_range(0, 2));
            for (int r = 0; r < nr; r++) begin
                do_read();
                check_model("random read");
            end
        end
        check_err("random errors");

        send_frame(8'h33, 1'b0, 1'b1);
        check_model("pre reset");
        bit_fall(1'b0);
        bit_rise();
        for (int i = 0; i < 4; i++) begin
            bit_fall(1'b1);
            bit_rise();
        end
        bit_fall(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midframe reset KBSR", kbsr, 16'h0000);
        check("midframe reset KBDR", kbdr, 16'h0000);
        check("midframe reset Overrun", {15'b0, ovr}, 16'h0000);
        check("midframe reset Frame_Err", {15'b0, ferr}, 16'h0000);
        q.delete();
        m_ovr = 1'b0;
        kbclk = 1'b1;
        kbdat = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        half();
        send_frame(8'hF0, 1'b0, 1'b1);
        check_model("after reset F0");
        check_err("no reset error");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
